// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a 2-cycle fast path for divide-by-zero and signed overflow.
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             DivZero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opd_q, opd_d;
    logic [2:0]           op_q, op_d;
    logic                 neg_q, neg_d;
    logic                 negr_q, negr_d;
    logic                 fast_q, fast_d;
    logic                 dzp_q, dzp_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic                 dz_q, dz_d;
    logic                 done_q, done_d;

    logic signed [WIDTH-1:0] a_s, b_s;
    logic                    sgn_a, sgn_b, a_neg, b_neg;
    logic                    is_div, b_zero, sgn_ovf, take_fast;
    logic [WIDTH-1:0]        a_mag, b_mag, fast_res;
    logic [WIDTH-1:0]        mul_addend;
    logic [WIDTH:0]          mul_sum;
    logic [2*WIDTH-1:0]      mul_next;
    logic [WIDTH:0]          rem_sh, div_diff;
    logic [2*WIDTH-1:0]      div_next;
    logic [2*WIDTH-1:0]      prod;
    logic [WIDTH-1:0]        quo, rem;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg2_if(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    always_comb begin
        a_s    = $signed(SrcA);
        b_s    = $signed(SrcB);
        is_div = Op[2];
        // Divides: signed unless U. Multiplies: A signed except MULHU, B signed for MUL/MULH only.
        sgn_a  = is_div ? ~Op[0] : (Op[1:0] != 2'b11);
        sgn_b  = is_div ? ~Op[0] : ~Op[1];
        a_neg  = sgn_a && (a_s < 0);
        b_neg  = sgn_b && (b_s < 0);
        a_mag  = neg_if(SrcA, a_neg);
        b_mag  = neg_if(SrcB, b_neg);
        b_zero = (SrcB == '0);
        sgn_ovf   = is_div && !Op[0] && (SrcA == MOST_NEG) && (SrcB == '1);
        take_fast = is_div && (b_zero || sgn_ovf);
        if (Op[1]) begin
            fast_res = b_zero ? SrcA : '0;
        end else begin
            fast_res = b_zero ? '1 : MOST_NEG;
        end
    end

    always_comb begin
        mul_addend = acc_q[0] ? opd_q : '0;
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
        mul_next   = {mul_sum, acc_q[WIDTH-1:1]};

        // Upper half holds the partial remainder, lower half shifts the dividend out / quotient in.
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = rem_sh - {1'b0, opd_q};
        if (div_diff[WIDTH]) begin
            div_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end

        prod = neg2_if(acc_q, neg_q);
        quo  = neg_if(acc_q[WIDTH-1:0], neg_q);
        rem  = neg_if(acc_q[2*WIDTH-1:WIDTH], negr_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opd_d   = opd_q;
        op_d    = op_q;
        neg_d   = neg_q;
        negr_d  = negr_q;
        fast_d  = fast_q;
        dzp_d   = dzp_q;
        res_d   = res_q;
        dz_d    = dz_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    op_d   = Op;
                    neg_d  = is_div ? (a_neg ^ b_neg) : (a_neg ^ b_neg);
                    negr_d = is_div && a_neg;
                    opd_d  = is_div ? b_mag : a_mag;
                    if (take_fast) begin
                        state_d = S_FIX;
                        // One settle cycle in FIX gives the fast path its 2-cycle latency.
                        cnt_d   = CNT_W'(1);
                        fast_d  = 1'b1;
                        dzp_d   = b_zero;
                        acc_d   = {{WIDTH{1'b0}}, fast_res};
                    end else begin
                        state_d = S_CALC;
                        cnt_d   = CNT_W'(WIDTH-1);
                        fast_d  = 1'b0;
                        dzp_d   = 1'b0;
                        acc_d   = {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
                    end
                end
            end
            S_CALC: begin
                acc_d = op_q[2] ? div_next : mul_next;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FIX: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    dz_d    = fast_q && dzp_q;
                    if (fast_q) begin
                        res_d = acc_q[WIDTH-1:0];
                    end else if (!op_q[2]) begin
                        res_d = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
                    end else begin
                        res_d = op_q[1] ? rem : quo;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything, including a Start in IDLE and a finishing FIX.
        if (Flush) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            res_d   = res_q;
            dz_d    = dz_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opd_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            negr_q  <= 1'b0;
            fast_q  <= 1'b0;
            dzp_q   <= 1'b0;
            res_q   <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opd_q   <= opd_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            negr_q  <= negr_d;
            fast_q  <= fast_d;
            dzp_q   <= dzp_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign Busy    = (state_q != S_IDLE);
    assign Done    = done_q;
    assign Result  = res_q;
    assign DivZero = dz_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed RV32M cases plus randomized ops checked against
// a plain-arithmetic reference model, with latency, Busy, Flush and reset checks.
module tb_mdu_iter;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          Start;
    logic [2:0]    Op;
    logic [W-1:0]  SrcA;
    logic [W-1:0]  SrcB;
    logic          Flush;
    logic          Busy;
    logic          Done;
    logic [W-1:0]  Result;
    logic          DivZero;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] last_res;

    mdu_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
        .Flush(Flush), .Busy(Busy), .Done(Done), .Result(Result), .DivZero(DivZero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: RV32M semantics straight from 64-bit integer arithmetic.
    function automatic logic [32:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint     sa, sb, ub, p;
        logic [63:0] up;
        logic [31:0] r;
        logic        dz;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'b0, b});
        dz  = o[2] && (b == 32'h0);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = 32'h0;
        case (o)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (ovf) r = 32'h8000_0000;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (ovf) r = 32'h0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return {dz, r};
    endfunction

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] m;
        int          n;
        int          exp_lat;
        bit          busy_ok;
        m = model(o, a, b);
        exp_lat = (o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 2 : W + 1;
        Start = 1'b1; Op = o; SrcA = a; SrcB = b;
        tick();
        Start = 1'b0; Op = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
        check({tag, ":done_width"}, 32'(Done), 32'd0);
        n = 0;
        busy_ok = 1'b1;
        while (Done !== 1'b1 && n < 200) begin
            if (Busy !== 1'b1) busy_ok = 1'b0;
            tick();
            n++;
        end
        check({tag, ":latency"}, 32'(n), 32'(exp_lat));
        check({tag, ":busy_while_running"}, 32'(busy_ok), 32'd1);
        check({tag, ":busy_in_done"}, 32'(Busy), 32'd0);
        check({tag, ":result"}, Result, m[31:0]);
        check({tag, ":divzero"}, 32'(DivZero), 32'(m[32]));
        last_res = m[31:0];
    endtask

    task automatic run_dir(input string tag, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        run_op(tag, o, a, b);
        check({tag, ":plan_value"}, Result, exp);
    endtask

    initial begin
        int  n;
        bit  seen;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        rst_n = 1'b0; Start = 1'b0; Flush = 1'b0; Op = 3'd0; SrcA = '0; SrcB = '0;
        last_res = '0;
        tick(); tick();
        check("reset:busy", 32'(Busy), 32'd0);
        check("reset:done", 32'(Done), 32'd0);
        check("reset:result", Result, 32'd0);
        check("reset:divzero", 32'(DivZero), 32'd0);
        rst_n = 1'b1;
        tick();

        run_dir("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        tick();
        run_dir("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_dir("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_dir("mulhsu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_dir("div_-7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_dir("rem_-7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_dir("rem_7_-2", 3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1);
        run_dir("divu_big", 3'd5, 32'hFFFF_FFFE, 32'd3, 32'h5555_5554);
        run_dir("divu_by0", 3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF);
        run_dir("rem_by0", 3'd6, 32'h1234, 32'd0, 32'h1234);
        run_dir("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_dir("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        tick();

        // Start pulsed mid-operation must be ignored.
        Start = 1'b1; Op = 3'd0; SrcA = 32'd5; SrcB = 32'd6;
        tick();
        Start = 1'b0;
        repeat (4) tick();
        Start = 1'b1; Op = 3'd5; SrcA = 32'd100; SrcB = 32'd7;
        tick();
        Start = 1'b0;
        n = 5;
        while (Done !== 1'b1 && n < 200) begin tick(); n++; end
        check("start_busy:latency", 32'(n), 32'd33);
        check("start_busy:result", Result, 32'd30);
        last_res = 32'd30;
        tick(); tick();
        check("start_busy:no_second_done", 32'(Done), 32'd0);

        // Flush at cycle 10 of a multiply.
        Start = 1'b1; Op = 3'd0; SrcA = 32'd11; SrcB = 32'd13;
        tick();
        Start = 1'b0;
        repeat (9) tick();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        check("flush:busy", 32'(Busy), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            if (Done === 1'b1) seen = 1'b1;
            tick();
        end
        check("flush:no_done", 32'(seen), 32'd0);
        check("flush:result_kept", Result, last_res);
        run_op("after_flush", 3'd0, 32'd11, 32'd13);
        tick();

        // Flush beats a simultaneous Start.
        Start = 1'b1; Flush = 1'b1; Op = 3'd0; SrcA = 32'd3; SrcB = 32'd3;
        tick();
        Start = 1'b0; Flush = 1'b0;
        check("flush_vs_start:busy", 32'(Busy), 32'd0);

        // Asynchronous reset in the middle of a divide.
        Start = 1'b1; Op = 3'd4; SrcA = 32'd1000; SrcB = 32'd7;
        tick();
        Start = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("async_rst:busy", 32'(Busy), 32'd0);
        check("async_rst:done", 32'(Done), 32'd0);
        check("async_rst:result", Result, 32'd0);
        check("async_rst:divzero", 32'(DivZero), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        seen = 1'b0;
        repeat (40) begin
            if (Done === 1'b1) seen = 1'b1;
            tick();
        end
        check("async_rst:no_done", 32'(seen), 32'd0);
        run_op("after_rst", 3'd4, 32'd1000, 32'hFFFF_FFF9);

        // Randomized ops, issued back-to-back in each Done cycle.
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom);
            case ($urandom % 8)
                0: ra = 32'h8000_0000;
                1: ra = 32'h0;
                default: ra = $urandom;
            endcase
            case ($urandom % 8)
                0: rb = 32'h0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom % 16);
                default: rb = $urandom;
            endcase
            run_op("rand", ro, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
